// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time,
// and holds the returned instruction for IF/ID until it is consumed or redirected.
module ifu_fetch #(
   parameter int unsigned           PC_WIDTH   = 64,
   parameter int unsigned           INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_PC   = 64'h0000_0000_8000_0000,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   input  logic                  stall,
   output logic                  imem_req_valid,
   output logic [PC_WIDTH-1:0]   imem_req_addr,
   input  logic                  imem_req_ready,
   input  logic                  imem_resp_valid,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   output logic [PC_WIDTH-1:0]   current_pc,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_valid
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP,
      S_HOLD
   } fetchState_t;

   fetchState_t           state;
   fetchState_t           stateNext;
   logic [PC_WIDTH-1:0]   pc;
   logic [PC_WIDTH-1:0]   pcNext;
   logic [INST_WIDTH-1:0] instBuf;
   logic [INST_WIDTH-1:0] instBufNext;
   logic [PC_WIDTH-1:0]   redirectTarget;

   assign redirectTarget = {redirect_pc[PC_WIDTH-1:2], 2'b00};

   assign imem_req_valid = (state == S_REQ) && !redirect_valid;
   assign imem_req_addr  = pc;
   assign current_pc     = pc;
   assign inst_valid     = (state == S_HOLD);
   assign inst           = inst_valid ? instBuf : NOP_INST;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         instBuf <= NOP_INST;
      end else begin
         state   <= stateNext;
         pc      <= pcNext;
         instBuf <= instBufNext;
      end
   end

   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      instBufNext = instBuf;
      case (state)
         S_REQ: begin
            if (redirect_valid) begin
               pcNext = redirectTarget;
            end else if (imem_req_ready) begin
               stateNext = S_WAIT;
            end
         end
         S_WAIT: begin
            // A redirect coinciding with the response makes that response stale.
            if (imem_resp_valid) begin
               if (redirect_valid) begin
                  pcNext    = redirectTarget;
                  stateNext = S_REQ;
               end else begin
                  instBufNext = imem_resp_data;
                  stateNext   = S_HOLD;
               end
            end else if (redirect_valid) begin
               pcNext    = redirectTarget;
               stateNext = S_DROP;
            end
         end
         S_DROP: begin
            if (redirect_valid) begin
               pcNext = redirectTarget;
            end
            if (imem_resp_valid) begin
               stateNext = S_REQ;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pcNext    = redirectTarget;
               stateNext = S_REQ;
            end else if (!stall) begin
               pcNext    = pc + PC_WIDTH'(4);
               stateNext = S_REQ;
            end
         end
         default: begin
            stateNext = S_REQ;
         end
      endcase
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized traffic, checked every
// cycle against a flag-based fetch model driving a variable-latency memory model.
module tb_ifu_fetch;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        stall;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [63:0] current_pc;
   logic [31:0] inst;
   logic        inst_valid;

   int unsigned nChecks = 0;
   int unsigned nFails  = 0;

   // reference model: what is held, whether a fetch is outstanding, whether it is stale
   logic [63:0] mPc;
   logic [31:0] mBuf;
   bit          mHeld;
   bit          mPending;
   bit          mStale;
   bit          mInit = 1'b0;

   // memory model
   bit          memBusy = 1'b0;
   int unsigned memDelay;
   logic [63:0] memAddr;

   always #5 clk = ~clk;

   ifu_fetch #(
      .PC_WIDTH  (64),
      .INST_WIDTH(32),
      .RESET_PC  (RESET_PC),
      .NOP_INST  (NOP_INST)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .current_pc     (current_pc),
      .inst           (inst),
      .inst_valid     (inst_valid)
   );

   function automatic logic [31:0] memData(input logic [63:0] addr);
      if (addr == 64'h0000_0000_8000_0000) return 32'h0050_0093;
      return addr[31:0] ^ addr[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs at negedge, check outputs, advance models,
   // return 1 time unit after the rising edge.
   task automatic stepCycle(input bit r, input bit redir, input logic [63:0] rpc,
                            input bit st, input bit rdy, input bit spur,
                            input int unsigned lat);
      logic [63:0] tgt;
      bit          expReq;
      bit          respV;
      logic [31:0] respD;
      @(negedge clk);
      respV = 1'b0;
      respD = $urandom;
      if (memBusy && memDelay == 0) begin
         respV = 1'b1;
         respD = memData(memAddr);
      end else if (!memBusy && spur) begin
         respV = 1'b1;
      end
      rst             = r;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      stall           = st;
      imem_req_ready  = rdy;
      imem_resp_valid = respV;
      imem_resp_data  = respD;
      #1;
      expReq = mInit && !mHeld && !mPending && !redir;
      if (mInit) begin
         checkVal("reqValid",  {63'd0, imem_req_valid}, {63'd0, expReq});
         checkVal("reqAddr",   imem_req_addr, mPc);
         checkVal("curPc",     current_pc, mPc);
         checkVal("instValid", {63'd0, inst_valid}, {63'd0, mHeld});
         checkVal("inst",      {32'd0, inst}, {32'd0, (mHeld ? mBuf : NOP_INST)});
      end
      // memory next state
      if (r) begin
         memBusy = 1'b0;
      end else if (memBusy) begin
         if (memDelay == 0) memBusy = 1'b0;
         else memDelay--;
      end else if (expReq && rdy) begin
         memBusy  = 1'b1;
         memAddr  = mPc;
         memDelay = lat - 1;
      end
      // fetch model next state
      tgt = {rpc[63:2], 2'b00};
      if (r) begin
         mPc = RESET_PC; mBuf = NOP_INST; mHeld = 0; mPending = 0; mStale = 0; mInit = 1;
      end else if (mHeld) begin
         if (redir) begin
            mPc = tgt; mHeld = 0;
         end else if (!st) begin
            mPc = mPc + 64'd4; mHeld = 0;
         end
      end else if (mPending) begin
         if (respV) begin
            if (!mStale && !redir) begin
               mBuf = respD; mHeld = 1;
            end
            if (redir) mPc = tgt;
            mPending = 0; mStale = 0;
         end else if (redir) begin
            mPc = tgt; mStale = 1;
         end
      end else if (mInit) begin
         if (redir) mPc = tgt;
         else if (rdy) begin
            mPending = 1; mStale = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] heldPc;
      logic [31:0] heldInst;
      // reset
      stepCycle(1, 0, '0, 0, 1, 0, 1);
      stepCycle(1, 0, '0, 0, 1, 0, 1);
      checkVal("rstInstValid", {63'd0, inst_valid}, 64'd0);
      checkVal("rstInst", {32'd0, inst}, {32'd0, NOP_INST});
      checkVal("rstPc", current_pc, RESET_PC);
      // first fetch with a 1-cycle memory
      stepCycle(0, 0, '0, 0, 1, 0, 1);
      stepCycle(0, 0, '0, 0, 1, 0, 1);
      checkVal("firstValid", {63'd0, inst_valid}, 64'd1);
      checkVal("firstPc", current_pc, 64'h0000_0000_8000_0000);
      checkVal("firstInst", {32'd0, inst}, 64'h0050_0093);
      // stall while holding
      heldPc = current_pc;
      heldInst = inst;
      for (int i = 0; i < 4; i++) begin
         stepCycle(0, 0, '0, 1, 1, 0, 1);
         checkVal("stallValid", {63'd0, inst_valid}, 64'd1);
         checkVal("stallInst", {32'd0, inst}, {32'd0, heldInst});
         checkVal("stallPc", current_pc, heldPc);
      end
      stepCycle(0, 0, '0, 0, 0, 0, 1);
      checkVal("nextAddr", imem_req_addr, 64'h0000_0000_8000_0004);
      // memory not ready for 3 cycles, then accept with a slow memory
      for (int i = 0; i < 3; i++) begin
         stepCycle(0, 0, '0, 0, 0, 0, 3);
         checkVal("notReadyAddr", imem_req_addr, 64'h0000_0000_8000_0004);
      end
      stepCycle(0, 0, '0, 0, 1, 0, 3);
      // redirect while waiting; the response lands two cycles later and is dropped
      stepCycle(0, 1, 64'h0000_0000_8000_0103, 0, 1, 0, 1);
      stepCycle(0, 0, '0, 0, 0, 0, 1);
      stepCycle(0, 0, '0, 0, 0, 0, 1);
      checkVal("dropValid", {63'd0, inst_valid}, 64'd0);
      checkVal("dropAddr", imem_req_addr, 64'h0000_0000_8000_0100);
      // fetch, then redirect beats stall in HOLD
      stepCycle(0, 0, '0, 1, 1, 0, 1);
      stepCycle(0, 0, '0, 1, 1, 0, 1);
      checkVal("holdValid", {63'd0, inst_valid}, 64'd1);
      stepCycle(0, 1, 64'h0000_0000_8000_0200, 1, 1, 0, 1);
      checkVal("redirHoldValid", {63'd0, inst_valid}, 64'd0);
      checkVal("redirHoldAddr", imem_req_addr, 64'h0000_0000_8000_0200);
      // reset in the middle of a wait; a late response must be ignored
      stepCycle(0, 0, '0, 0, 1, 0, 3);
      stepCycle(0, 0, '0, 0, 1, 0, 3);
      stepCycle(1, 0, '0, 0, 1, 0, 3);
      checkVal("midRstPc", current_pc, RESET_PC);
      checkVal("midRstInst", {32'd0, inst}, {32'd0, NOP_INST});
      stepCycle(0, 0, '0, 0, 0, 1, 1);
      checkVal("lateRespValid", {63'd0, inst_valid}, 64'd0);
      // PC wrap at the top of the address space
      stepCycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 1);
      stepCycle(0, 0, '0, 0, 1, 0, 1);
      stepCycle(0, 0, '0, 0, 1, 0, 1);
      checkVal("wrapPc", current_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      stepCycle(0, 0, '0, 0, 0, 0, 1);
      checkVal("wrapAddr", imem_req_addr, 64'd0);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic [63:0] rpc;
         rpc = {$urandom, $urandom};
         if ($urandom_range(3) == 0) rpc = {32'hFFFF_FFFF, 28'hFFF_FFFF, rpc[3:0]};
         stepCycle(($urandom_range(199) == 0),
                   ($urandom_range(7) == 0),
                   rpc,
                   ($urandom_range(2) == 0),
                   ($urandom_range(2) != 0),
                   ($urandom_range(9) == 0),
                   $urandom_range(3, 1));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response channel.
- Holds each returned instruction with its PC for the decode side until consumed.
- Handles redirects from branches/jumps (including dropping an in-flight stale response) and stalls from downstream.

Parameters:
- PC_WIDTH, 64, width of PC and memory address.
- INST_WIDTH, 32, instruction width.
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset.
- NOP_INST, 32'h0000_0013, instruction presented when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  redirect request from execute (branch taken / jump / flush).
- redirect_pc  in  PC_WIDTH  redirect target; bits [1:0] ignored (stored as 0).
- stall  in  1  downstream cannot accept the held instruction this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  PC_WIDTH  fetch address (= pc).
- imem_req_ready  in  1  memory accepts request.
- imem_resp_valid  in  1  response valid (one per accepted request, in order, >=1 cycle after acceptance).
- imem_resp_data  in  INST_WIDTH  fetched instruction.
- current_pc  out  PC_WIDTH  PC of held instruction (= pc register).
- inst  out  INST_WIDTH  held instruction, or NOP_INST when inst_valid=0.
- inst_valid  out  1  held instruction is valid for IF/ID.

Behaviour:
- State: pc register, inst_buf register, 2-bit FSM {S_REQ, S_WAIT, S_DROP, S_HOLD}.
- Reset (rst=1 at edge): pc<=RESET_PC, inst_buf<=NOP_INST, state<=S_REQ; overrides all other inputs.
  - Resulting outputs: imem_req_valid=1 (unless redirect_valid), inst_valid=0, inst=NOP_INST, current_pc=RESET_PC.
  - The memory shares rst and discards outstanding transactions; any response arriving in S_REQ is ignored.
- Outputs (Moore, except imem_req_valid):
  - imem_req_valid = (state==S_REQ) && !redirect_valid.
  - imem_req_addr = pc.
  - inst_valid = (state==S_HOLD).
  - inst = inst_valid ? inst_buf : NOP_INST.
  - current_pc = pc.
- S_REQ:
  - redirect_valid → pc<=redirect_pc&~3, stay S_REQ (no request issued this cycle).
  - else imem_req_valid&&imem_req_ready → S_WAIT.
  - else stay.
- S_WAIT:
  - resp_valid && redirect_valid → discard data, pc<=redirect target, S_REQ.
  - resp_valid only → inst_buf<=imem_resp_data, S_HOLD.
  - redirect_valid only → pc<=redirect target, S_DROP.
  - neither → stay.
- S_DROP:
  - redirect_valid → pc<=redirect target (latest wins).
  - resp_valid → discard data, S_REQ.
  - Both in same cycle → both actions apply.
- S_HOLD:
  - redirect_valid → pc<=redirect target, S_REQ; redirect beats stall and consume.
  - else !stall → instruction consumed this cycle, pc<=pc+4, S_REQ.
  - else stay; outputs stable.
- PC arithmetic: pc+4 modulo 2^PC_WIDTH (wraps, no flag).
- Latency: with a 1-cycle memory, 3 cycles per instruction (REQ, WAIT, HOLD). First inst_valid is 3 cycles after rst deasserts.
- At most one outstanding request; imem_resp_valid outside S_WAIT/S_DROP is ignored.

Test Plan:
- Reset then 1-cycle memory, ready=1, stall=0, mem[0x80000000]=0x00500093 → inst_valid=1 in cycle 3 with current_pc=0x80000000, inst=0x00500093; next request addr 0x80000004.
- stall=1 for 4 cycles while in S_HOLD → inst_valid, inst, current_pc unchanged, no imem_req_valid; stall=0 → next cycle imem_req_addr=pc+4.
- imem_req_ready=0 for 3 cycles → imem_req_valid and imem_req_addr held constant; transition to S_WAIT only on the cycle ready=1.
- redirect_valid with redirect_pc=0x80000103 while in S_WAIT, response 2 cycles later → that response dropped (inst_valid stays 0), next request addr 0x80000100.
- redirect in S_HOLD with stall=1 → inst_valid=0 next cycle, imem_req_addr=redirect target; rst asserted mid-S_WAIT → next cycle pc=RESET_PC, inst=NOP_INST, late response ignored.
- pc=0xFFFF_FFFF_FFFF_FFFC consumed → next imem_req_addr=0x0.
